// File: rtl/viterbi_channel_injector_pkg.sv
// Shared types, constants and helpers for the Viterbi noisy-channel injector.
package viterbi_chan_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_RANDOM = 2'd1,
        MODE_BURST  = 2'd2,
        MODE_FORCED = 2'd3
    } inj_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } inj_state_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [1:0] popcount2(input logic [1:0] m);
        return {m[1] & m[0], m[1] ^ m[0]};
    endfunction

endpackage

// File: rtl/viterbi_channel_injector_if.sv
// Symbol stream between encoder, channel injector and decoder.
interface viterbi_channel_injector_if;
    logic       sym_valid_i;
    logic [1:0] sym_i;
    logic       sym_valid_o;
    logic [1:0] sym_o;
    logic [1:0] err_mask_o;

    modport master (
        output sym_valid_i, sym_i,
        input  sym_valid_o, sym_o, err_mask_o
    );

    modport slave (
        input  sym_valid_i, sym_i,
        output sym_valid_o, sym_o, err_mask_o
    );
endinterface

// File: rtl/viterbi_channel_injector_lfsr.sv
// 32-bit right-shifting Galois LFSR; advances only when requested.
module chan_lfsr32
    import viterbi_chan_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= seed;
        end else if (advance) begin
            state <= state[0] ? ((state >> 1) ^ LFSR_POLY) : (state >> 1);
        end
    end

endmodule

// File: rtl/viterbi_channel_injector.sv
// Noisy-channel stage: registers each encoded symbol and applies an optional
// error mask chosen by mode (off, random, burst, forced), with saturating stats.
module viterbi_channel_injector
    import viterbi_chan_pkg::*;
#(
    parameter int unsigned RATE_LOG2 = 6,
    parameter int unsigned BURST_LEN = 2,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               cfg_mode,
    input  logic [1:0]               cfg_pattern,
    input  logic                     cnt_clr,
    viterbi_channel_injector_if.slave sym_if,
    output logic [CNT_W-1:0]         flip_cnt_o,
    output logic [CNT_W-1:0]         sym_cnt_o
);

    localparam logic [31:0] TRIG_MASK    = (32'd1 << RATE_LOG2) - 32'd1;
    localparam logic [7:0]  BURST_RELOAD = 8'(BURST_LEN - 1);
    localparam int unsigned SW           = CNT_W + 1;

    inj_mode_e   mode;
    inj_state_e  state_q, state_d;
    logic [7:0]  rem_q, rem_d;
    logic [1:0]  bmask_q, bmask_d;
    logic [1:0]  mask;
    logic [31:0] lfsr_q;
    logic [1:0]  lfsr_hi;
    logic        trig;

    logic             valid_q;
    logic [1:0]       sym_q;
    logic [1:0]       err_q;
    logic [CNT_W-1:0] flip_q, symc_q;
    logic [SW-1:0]    flip_sum, sym_sum;

    assign mode    = inj_mode_e'(cfg_mode);
    assign lfsr_hi = lfsr_q[29:28];
    assign trig    = ((lfsr_q & TRIG_MASK) == TRIG_MASK);

    chan_lfsr32 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .seed    (LFSR_SEED),
        .advance (sym_if.sym_valid_i),
        .state   (lfsr_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            bmask_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            bmask_q <= bmask_d;
        end
    end

    // Leaving burst mode drops any partial burst on any cycle, so re-entry starts idle.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        bmask_d = bmask_q;
        mask    = '0;
        if (mode != MODE_BURST) begin
            state_d = ST_IDLE;
        end
        if (sym_if.sym_valid_i) begin
            case (mode)
                MODE_OFF:    mask = '0;
                MODE_FORCED: mask = cfg_pattern;
                MODE_RANDOM: mask = trig ? lfsr_hi : 2'b00;
                MODE_BURST: begin
                    if (state_q == ST_BURST) begin
                        mask  = bmask_q;
                        rem_d = rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            state_d = ST_IDLE;
                        end
                    end else if (trig) begin
                        bmask_d = (lfsr_hi == 2'b00) ? 2'b11 : lfsr_hi;
                        mask    = bmask_d;
                        if (BURST_LEN > 1) begin
                            rem_d   = BURST_RELOAD;
                            state_d = ST_BURST;
                        end
                    end
                end
                default: mask = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            sym_q   <= '0;
            err_q   <= '0;
        end else begin
            valid_q <= sym_if.sym_valid_i;
            err_q   <= mask;
            if (sym_if.sym_valid_i) begin
                sym_q <= sym_if.sym_i ^ mask;
            end
        end
    end

    assign sym_if.sym_valid_o = valid_q;
    assign sym_if.sym_o       = sym_q;
    assign sym_if.err_mask_o  = err_q;

    // One extra bit on each sum exposes the overflow used for saturation.
    assign flip_sum = {1'b0, flip_q} + SW'(popcount2(mask));
    assign sym_sum  = {1'b0, symc_q} + SW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flip_q <= '0;
            symc_q <= '0;
        end else if (cnt_clr) begin
            flip_q <= '0;
            symc_q <= '0;
        end else if (sym_if.sym_valid_i) begin
            flip_q <= flip_sum[CNT_W] ? '1 : flip_sum[CNT_W-1:0];
            symc_q <= sym_sum[CNT_W]  ? '1 : sym_sum[CNT_W-1:0];
        end
    end

    assign flip_cnt_o = flip_q;
    assign sym_cnt_o  = symc_q;

endmodule

// File: tb/tb_viterbi_channel_injector.sv
// Directed bench: three injector configurations share one stimulus stream and are
// checked per symbol against a behavioural channel model through scoreboard queues.
module tb_viterbi_channel_injector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] cfg_mode = 2'd0;
    logic [1:0] cfg_pattern = 2'd0;
    logic       cnt_clr = 1'b0;

    viterbi_channel_injector_if ifa();
    viterbi_channel_injector_if ifb();
    viterbi_channel_injector_if ifc();

    assign ifb.sym_valid_i = ifa.sym_valid_i;
    assign ifb.sym_i       = ifa.sym_i;
    assign ifc.sym_valid_i = ifa.sym_valid_i;
    assign ifc.sym_i       = ifa.sym_i;

    logic [15:0] fa, sa, fb, sb;
    logic [3:0]  fc, sc;

    always #5 clk = ~clk;

    viterbi_channel_injector u_a (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_pattern(cfg_pattern),
        .cnt_clr(cnt_clr), .sym_if(ifa.slave), .flip_cnt_o(fa), .sym_cnt_o(sa)
    );

    viterbi_channel_injector #(.RATE_LOG2(1), .BURST_LEN(3)) u_b (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_pattern(cfg_pattern),
        .cnt_clr(cnt_clr), .sym_if(ifb.slave), .flip_cnt_o(fb), .sym_cnt_o(sb)
    );

    viterbi_channel_injector #(.CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_pattern(cfg_pattern),
        .cnt_clr(cnt_clr), .sym_if(ifc.slave), .flip_cnt_o(fc), .sym_cnt_o(sc)
    );

    typedef struct {
        bit         bst;
        int         brem;
        logic [1:0] bmask;
        int         symc;
        int         flipc;
        logic [1:0] last;
    } mdl_t;

    int          total = 0;
    int          bad = 0;
    mdl_t        md[3];
    logic [3:0]  sbq[3][$];
    logic [31:0] ml;
    int          rate[3] = '{6, 1, 6};
    int          blen[3] = '{2, 3, 2};
    int          cmax[3] = '{65535, 65535, 15};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ml = 32'hACE1_2468;
        for (int k = 0; k < 3; k++) begin
            md[k] = '{bst: 1'b0, brem: 0, bmask: 2'b00, symc: 0, flipc: 0, last: 2'b00};
            sbq[k].delete();
        end
    endtask

    task automatic check_out(input int k);
        logic        ov;
        logic [1:0]  os, om;
        logic [31:0] cs, cf;
        logic [3:0]  e;
        case (k)
            0:       begin ov = ifa.sym_valid_o; os = ifa.sym_o; om = ifa.err_mask_o; cs = 32'(sa); cf = 32'(fa); end
            1:       begin ov = ifb.sym_valid_o; os = ifb.sym_o; om = ifb.err_mask_o; cs = 32'(sb); cf = 32'(fb); end
            default: begin ov = ifc.sym_valid_o; os = ifc.sym_o; om = ifc.err_mask_o; cs = 32'(sc); cf = 32'(fc); end
        endcase
        if (sbq[k].size() > 0) begin
            e = sbq[k].pop_front();
            chk($sformatf("valid[%0d]", k), 32'(ov), 32'd1);
            chk($sformatf("sym_o[%0d]", k), 32'(os), 32'(e[3:2]));
            chk($sformatf("mask[%0d]", k), 32'(om), 32'(e[1:0]));
            md[k].last = e[3:2];
        end else begin
            chk($sformatf("idle_valid[%0d]", k), 32'(ov), 32'd0);
            chk($sformatf("idle_sym[%0d]", k), 32'(os), 32'(md[k].last));
            chk($sformatf("idle_mask[%0d]", k), 32'(om), 32'd0);
        end
        chk($sformatf("sym_cnt[%0d]", k), cs, 32'(md[k].symc));
        chk($sformatf("flip_cnt[%0d]", k), cf, 32'(md[k].flipc));
    endtask

    task automatic step(input logic v, input logic [1:0] s, input logic clr);
        logic [31:0] mk;
        logic        trig;
        logic [1:0]  m;
        ifa.sym_valid_i = v;
        ifa.sym_i       = s;
        cnt_clr         = clr;
        for (int k = 0; k < 3; k++) begin
            if (cfg_mode != 2'd2) md[k].bst = 1'b0;
            if (v) begin
                mk   = (32'd1 << rate[k]) - 32'd1;
                trig = ((ml & mk) == mk);
                m    = 2'b00;
                case (cfg_mode)
                    2'd1: m = trig ? ml[29:28] : 2'b00;
                    2'd3: m = cfg_pattern;
                    2'd2: begin
                        if (md[k].bst) begin
                            m = md[k].bmask;
                            md[k].brem--;
                            if (md[k].brem == 0) md[k].bst = 1'b0;
                        end else if (trig) begin
                            md[k].bmask = (ml[29:28] == 2'b00) ? 2'b11 : ml[29:28];
                            m = md[k].bmask;
                            if (blen[k] > 1) begin
                                md[k].brem = blen[k] - 1;
                                md[k].bst  = 1'b1;
                            end
                        end
                    end
                    default: m = 2'b00;
                endcase
                sbq[k].push_back({s ^ m, m});
                md[k].symc  = (md[k].symc + 1 > cmax[k]) ? cmax[k] : md[k].symc + 1;
                md[k].flipc = (md[k].flipc + int'(m[0]) + int'(m[1]) > cmax[k]) ?
                              cmax[k] : md[k].flipc + int'(m[0]) + int'(m[1]);
            end
            if (clr) begin
                md[k].symc  = 0;
                md[k].flipc = 0;
            end
        end
        if (v) ml = ml[0] ? ((ml >> 1) ^ 32'h8020_0003) : (ml >> 1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_out(k);
    endtask

    task automatic do_reset(input logic v);
        ifa.sym_valid_i = v;
        ifa.sym_i       = 2'b11;
        cnt_clr         = 1'b0;
        rst             = 1'b1;
        #2;
        chk("rst_valid_a", 32'(ifa.sym_valid_o), 32'd0);
        chk("rst_sym_b", 32'(ifb.sym_o), 32'd0);
        chk("rst_mask_b", 32'(ifb.err_mask_o), 32'd0);
        chk("rst_valid_b", 32'(ifb.sym_valid_o), 32'd0);
        chk("rst_cnt_b", {fb, sb}, 32'd0);
        chk("rst_cnt_c", {24'd0, fc, sc}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_b", {29'd0, ifb.sym_valid_o, ifb.err_mask_o}, 32'd0);
        ifa.sym_valid_i = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nz;
        int guard;
        ifa.sym_valid_i = 1'b0;
        ifa.sym_i = 2'b00;
        model_reset();
        @(negedge clk);
        do_reset(1'b0);

        // OFF: transparent one-cycle pipeline
        cfg_mode = 2'd0;
        for (int i = 0; i < 100; i++) step(1'b1, 2'(i), 1'b0);
        chk("off_sym_cnt", 32'(sa), 32'd100);
        chk("off_flip_cnt", 32'(fa), 32'd0);

        // FORCED pattern 10 on symbol 11
        cfg_mode = 2'd3;
        cfg_pattern = 2'b10;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 2'b11, 1'b0);
            chk("forced_sym", 32'(ifa.sym_o), 32'b01);
        end
        chk("forced_flip_cnt", 32'(fa), 32'd10);
        step(1'b1, 2'b11, 1'b1);
        chk("clr_cnts", {fa, sa}, 32'd0);

        // Saturation of the narrow counter
        cfg_pattern = 2'b11;
        for (int i = 0; i < 10; i++) step(1'b1, 2'b00, 1'b0);
        chk("sat_flip_c", 32'(fc), 32'd15);
        chk("sat_sym_c", 32'(sc), 32'd10);

        // RANDOM with gaps between valid symbols
        cfg_mode = 2'd1;
        for (int i = 0; i < 4096; i++) begin
            if ($urandom_range(3) == 0) begin
                for (int g = 0; g <= int'($urandom_range(2)); g++) step(1'b0, 2'($urandom), 1'b0);
            end
            step(1'b1, 2'($urandom), 1'b0);
        end
        chk("rand_sym_cnt", 32'(sa), 32'd4106);
        chk("rand_flip_cnt", 32'(fa), 32'(md[0].flipc));

        // BURST: nonzero runs come in whole bursts of three
        cfg_mode = 2'd2;
        nz = 0;
        guard = 0;
        for (int i = 0; i < 150 || (md[1].bst && guard < 10); i++) begin
            if (i >= 150) guard++;
            if ($urandom_range(4) == 0) step(1'b0, 2'b00, 1'b0);
            step(1'b1, 2'($urandom), 1'b0);
            if (ifb.err_mask_o != 2'b00) nz++;
        end
        chk("burst_runlen", 32'(nz % 3), 32'd0);
        chk("burst_seen", 32'(nz > 0), 32'd1);

        // Leave BURST mid-burst: next symbol clean
        guard = 0;
        while (!md[1].bst && guard < 50) begin
            step(1'b1, 2'b01, 1'b0);
            guard++;
        end
        chk("burst_entered", 32'(md[1].bst), 32'd1);
        cfg_mode = 2'd0;
        step(1'b1, 2'b01, 1'b0);
        chk("off_after_burst", {30'd0, ifb.err_mask_o}, 32'd0);
        chk("off_after_burst_sym", 32'(ifb.sym_o), 32'b01);

        // Reset on the 2nd symbol of a burst, then golden sequence from seed
        cfg_mode = 2'd2;
        guard = 0;
        while (!(md[1].bst && md[1].brem == 2) && guard < 50) begin
            step(1'b1, 2'b10, 1'b0);
            guard++;
        end
        chk("burst_first_sym", 32'(md[1].brem), 32'd2);
        do_reset(1'b1);
        for (int i = 0; i < 40; i++) step(1'b1, 2'(i), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/viterbi_channel_injector.md
Name: viterbi_channel_injector

Overview:
- Synthesizable noisy-channel stage between the convolutional encoder and the Viterbi decoder.
- Registers each 2-bit encoded symbol and optionally flips bits under an LFSR-driven rate, burst or forced-pattern policy.
- Counts symbols passed and bits flipped, so the bench can compare decoder output against the known channel error load.

Parameters:
- RATE_LOG2, 6: random trigger fires when the low RATE_LOG2 bits of the LFSR are all ones (mean one trigger per 2**RATE_LOG2 symbols). Legal range 1..16.
- BURST_LEN, 2: consecutive corrupted symbols per burst trigger. Legal range 1..255.
- LFSR_SEED, 32'hACE1_2468: LFSR reset value. Must be nonzero.
- CNT_W, 16: width of both statistics counters.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_mode  in  2  injection mode: 0 OFF, 1 RANDOM, 2 BURST, 3 FORCED
- cfg_pattern  in  2  flip mask used in FORCED mode
- cnt_clr  in  1  synchronous clear of both counters
- sym_valid_i  in  1  encoder symbol valid
- sym_i  in  2  encoder symbol
- sym_valid_o  out  1  symbol valid toward the decoder
- sym_o  out  2  possibly corrupted symbol
- err_mask_o  out  2  mask applied to the current sym_o
- flip_cnt_o  out  CNT_W  total bits flipped, saturating
- sym_cnt_o  out  CNT_W  total symbols output, saturating

Behaviour:
- Reset values: sym_valid_o=0, sym_o=0, err_mask_o=0, both counters 0, LFSR=LFSR_SEED, FSM=IDLE, burst counter 0.
- Latency: exactly 1 cycle. Registered outputs: sym_valid_o<=sym_valid_i; sym_o<=sym_i^mask; err_mask_o<=mask.
- sym_valid_i=0: sym_valid_o<=0, sym_o holds its previous value, err_mask_o<=0, LFSR and FSM hold.
- LFSR: 32-bit Galois, polynomial 0x80200003, shifts right.
  - Advances once per sym_valid_i=1 in every mode, so the sequence depends only on the symbol index.
  - All mask and trigger decisions use the pre-advance value L.
  - trig = (L[RATE_LOG2-1:0] all ones).
- Mask selection (valid cycles only):
  - OFF: mask=00.
  - FORCED: mask=cfg_pattern.
  - RANDOM: mask = trig ? L[29:28] : 00. A trigger with L[29:28]=00 is legal and flips nothing.
  - BURST: FSM states IDLE and BURST.
    - IDLE with trig: latch bmask = (L[29:28]==00) ? 11 : L[29:28]; apply bmask to this symbol.
    - If BURST_LEN>1: load remaining=BURST_LEN-1 and go to BURST. If BURST_LEN=1: stay in IDLE.
    - In BURST: apply bmask to every valid symbol and ignore trig. Decrement remaining; return to IDLE after the symbol that makes it 0.
    - Every burst therefore corrupts exactly BURST_LEN valid symbols with a nonzero mask. Invalid cycles inside a burst do not consume it.
- cfg_mode change:
  - Takes effect on the next valid symbol.
  - Leaving BURST mode forces the FSM to IDLE and discards the remaining burst.
  - Re-entering BURST mode starts in IDLE.
- Counters: on each output-valid symbol, sym_cnt += 1 and flip_cnt += popcount(mask). Both saturate at all ones with no wrap.
- cnt_clr=1 zeroes both counters that cycle. An increment in the same cycle is dropped (clear wins).
- Reset asserted mid-burst: immediately returns every register to its reset value. Any in-flight symbol is lost.

Decomposition:
- Shared package viterbi_chan_pkg holds:
  - inj_mode_e enum {OFF, RANDOM, BURST, FORCED}
  - inj_state_e enum {IDLE, BURST}
  - LFSR_POLY constant = 32'h80200003
  - popcount2 function
- One sub-module, chan_lfsr32, with ports clk, rst, seed, advance and a 32-bit state output.

Test Plan:
- OFF mode, 100 valid symbols of incrementing sym_i[1:0] -> sym_o equals sym_i delayed 1 cycle; err_mask_o=00 throughout; sym_cnt_o=100; flip_cnt_o=0.
- FORCED with cfg_pattern=10 and sym_i=11 for 10 symbols -> sym_o=01 each cycle; flip_cnt_o=10. Then cnt_clr pulse coincident with a valid symbol -> both counters read 0 afterward.
- RANDOM, RATE_LOG2=6, 4096 symbols with random valid gaps -> per-symbol err_mask_o matches a bit-exact LFSR golden model indexed by symbol count; flip_cnt_o equals the model's popcount sum; gaps do not change the sequence.
- BURST, RATE_LOG2=1, BURST_LEN=3 -> every nonzero-mask run is exactly 3 valid symbols with a constant nonzero mask, and no retrigger occurs inside a run. Switch to OFF mid-burst -> the next symbol is clean.
- Assert rst on the 2nd symbol of a BURST_LEN=3 burst -> all outputs 0. After release, the LFSR restarts from LFSR_SEED and the first masks reproduce the post-reset golden sequence.
- CNT_W=4, FORCED with pattern 11 for 10 symbols -> flip_cnt_o stops at 15 and does not wrap; sym_cnt_o=10.
